// File: rtl/uart_tx_fifo.sv
// Byte FIFO between a CPU register port and a UART register slave; a drain FSM forwards bytes while the UART is idle.
// Optional interrupt output and CTRL.irq_en bit are built when UART_TX_FIFO_IRQ_EN is defined.
module uart_tx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] s_addr_i,
  input  logic [31:0] s_data_i,
  input  logic [3:0]  s_sel_i,
  input  logic        s_we_i,
  output logic [31:0] s_data_o,
  output logic [31:0] m_addr_o,
  output logic [31:0] m_data_o,
  output logic [3:0]  m_sel_o,
  output logic        m_we_o,
  input  logic [31:0] m_data_i
`ifdef UART_TX_FIFO_IRQ_EN
  ,
  output logic        irq_o
`endif
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_STAT = 2'd1,
    CHK     = 2'd2,
    WR      = 2'd3
  } state_t;

  state_t        r_state;
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          r_drain_en;
  logic          r_overflow;

  logic          w_wr_ctrl;
  logic          w_wr_stat;
  logic          w_wr_txd;
  logic          w_flush;
  logic          w_push;
  logic          w_pop;
  logic          w_empty;
  logic          w_full;
  logic          w_irq_en;
  logic [8:0]    w_count9;
  logic [31:0]   w_rdata;
  logic          w_unused;

  assign w_wr_ctrl = s_we_i & s_sel_i[0] & (s_addr_i[7:0] == 8'h00);
  assign w_wr_stat = s_we_i & s_sel_i[0] & (s_addr_i[7:0] == 8'h04);
  assign w_wr_txd  = s_we_i & s_sel_i[0] & (s_addr_i[7:0] == 8'h08);
  assign w_flush   = w_wr_ctrl & s_data_i[1];
  assign w_empty   = (r_count == {(AW+1){1'b0}});
  assign w_full    = (r_count == (AW+1)'(DEPTH));
  assign w_push    = w_wr_txd & ~w_full;
  assign w_pop     = (r_state == WR);
  assign w_count9  = 9'(r_count);
  assign w_unused  = ^{s_addr_i[31:8], s_data_i[31:8], s_sel_i[3:1], m_data_i[31:1]};

  // Control bits and the sticky overflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drain_en <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_ctrl) r_drain_en <= s_data_i[0];
      if (w_wr_txd & w_full) r_overflow <= 1'b1;
      else if (w_wr_stat & s_data_i[2]) r_overflow <= 1'b0;
    end
  end

  // Storage carries no reset: pointers and count alone define validity
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= s_data_i[7:0];
  end

  // Pointers and occupancy; flush wins over a same-edge push or pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= {AW{1'b0}};
      r_rptr  <= {AW{1'b0}};
      r_count <= {(AW+1){1'b0}};
    end else if (w_flush) begin
      r_wptr  <= {AW{1'b0}};
      r_rptr  <= {AW{1'b0}};
      r_count <= {(AW+1){1'b0}};
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Slave read mux
  always_comb begin
    w_rdata = 32'h0;
    case (s_addr_i[7:0])
      8'h00:   w_rdata = {29'h0, w_irq_en, 1'b0, r_drain_en};
      8'h04:   w_rdata = {15'h0, w_count9, 5'h0, r_overflow, w_full, w_empty};
      default: w_rdata = 32'h0;
    endcase
  end

  // Registered slave read data; a write cycle returns zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s_data_o <= 32'h0;
    else if (s_we_i) s_data_o <= 32'h0;
    else s_data_o <= w_rdata;
  end

  // Drain FSM; master outputs are registered alongside the state they belong to
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      m_addr_o <= 32'h0;
      m_data_o <= 32'h0;
      m_sel_o  <= 4'h0;
      m_we_o   <= 1'b0;
    end else begin
      m_addr_o <= 32'h0;
      m_data_o <= 32'h0;
      m_sel_o  <= 4'h0;
      m_we_o   <= 1'b0;
      if (w_flush) begin
        r_state <= IDLE;
      end else begin
        case (r_state)
          IDLE: begin
            if (r_drain_en && !w_empty) begin
              r_state  <= RD_STAT;
              m_addr_o <= 32'h4;
            end else begin
              r_state <= IDLE;
            end
          end
          RD_STAT: r_state <= CHK;
          CHK: begin
            if (m_data_i[0]) begin
              r_state  <= RD_STAT;
              m_addr_o <= 32'h4;
            end else begin
              r_state  <= WR;
              m_addr_o <= 32'hC;
              m_we_o   <= 1'b1;
              m_sel_o  <= 4'b0001;
              m_data_o <= {24'h0, r_mem[r_rptr]};
            end
          end
          WR:      r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

`ifdef UART_TX_FIFO_IRQ_EN
  logic r_irq_en;
  logic w_irq_en_nxt;
  logic w_drain_en_nxt;

  assign w_irq_en       = r_irq_en;
  assign w_irq_en_nxt   = w_wr_ctrl ? s_data_i[2] : r_irq_en;
  assign w_drain_en_nxt = w_wr_ctrl ? s_data_i[0] : r_drain_en;

  // Interrupt enable and registered "drained and idle" interrupt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_irq_en <= 1'b0;
      irq_o    <= 1'b0;
    end else begin
      if (w_wr_ctrl) r_irq_en <= s_data_i[2];
      irq_o <= w_irq_en_nxt & w_drain_en_nxt & w_empty & (r_state == IDLE);
    end
  end
`else
  assign w_irq_en = 1'b0;
`endif

endmodule
